branch_predictor: RTL and testbench

- Parametrised gshare direction predictor with a tagged branch target buffer (BTB) for the RISC-V pipeline.
- The fetch stage queries it with the fetch PC and receives a registered prediction one cycle later, aligned with decode.
- Resolved conditional branches from execute train the pattern history table (PHT), global history register (GHR) and BTB.
- It replaces the fixed decode-time target logic with a configurable-size, configurable-history predictor and adds mispredict statistics.

---
 rtl/branch_predictor.sv | 143 ++++++++++++++
 tb/tb_branch_predictor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// gshare direction predictor with a tagged, direct-mapped BTB.
// Lookup answers one cycle later; resolved branches train PHT, BTB, GHR.
module branch_predictor #(
  parameter int ENTRIES    = 64,
  parameter int HIST_BITS  = 6,
  parameter int CTR_BITS   = 2,
  parameter int TAG_BITS   = 8,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bp_enable,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_pc,
  output logic                  pred_valid,
  output logic [31:0]           pred_pc,
  output logic                  pred_taken,
  output logic [31:0]           pred_target,
  input  logic                  upd_valid,
  input  logic [31:0]           upd_pc,
  input  logic                  upd_taken,
  input  logic [31:0]           upd_target,
  input  logic                  upd_mispredict,
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TLO = IDX + 2;
  localparam logic [CTR_BITS-1:0] CTR_INIT =
    CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

  logic [CTR_BITS-1:0] pht_q     [ENTRIES];
  logic                btb_v_q   [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_q [ENTRIES];
  logic [31:0]         btb_tgt_q [ENTRIES];

  logic                  pred_valid_q, pred_taken_q;
  logic [31:0]           pred_pc_q, pred_tgt_q;
  logic [STAT_WIDTH-1:0] br_q, mp_q;
  logic [IDX-1:0]        hist;

  generate
    if (HIST_BITS > 0) begin : g_ghr
      logic [HIST_BITS-1:0] ghr_q;
      logic [HIST_BITS:0]   sh;
      assign sh   = {ghr_q, upd_taken};
      assign hist = IDX'(ghr_q);
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) ghr_q <= '0;
        else if (upd_valid) ghr_q <= sh[HIST_BITS-1:0];
      end
    end else begin : g_bimodal
      assign hist = '0;
    end
  endgenerate

  logic [IDX-1:0]      lk_bidx, lk_pidx, up_bidx, up_pidx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                lk_hit;
  logic [CTR_BITS-1:0] ctr_cur, ctr_d;
  logic                unused_ok;

  assign lk_bidx = lookup_pc[IDX+1:2];
  assign lk_pidx = lk_bidx ^ hist;
  assign lk_tag  = lookup_pc[TLO+TAG_BITS-1:TLO];
  assign up_bidx = upd_pc[IDX+1:2];
  assign up_pidx = up_bidx ^ hist;
  assign up_tag  = upd_pc[TLO+TAG_BITS-1:TLO];
  assign unused_ok = ^{lookup_pc, upd_pc};

  assign lk_hit = bp_enable
                & pht_q[lk_pidx][CTR_BITS-1]
                & btb_v_q[lk_bidx]
                & (btb_tag_q[lk_bidx] == lk_tag);

  assign ctr_cur = pht_q[up_pidx];

  always_comb begin
    ctr_d = ctr_cur;
    if (upd_taken && ctr_cur != CTR_MAX)
      ctr_d = ctr_cur + CTR_BITS'(1);
    else if (!upd_taken && ctr_cur != '0)
      ctr_d = ctr_cur - CTR_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i]     <= CTR_INIT;
        btb_v_q[i]   <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
    end else if (upd_valid) begin
      pht_q[up_pidx] <= ctr_d;
      if (upd_taken) begin
        btb_v_q[up_bidx]   <= 1'b1;
        btb_tag_q[up_bidx] <= up_tag;
        btb_tgt_q[up_bidx] <= upd_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_pc_q    <= '0;
      pred_tgt_q   <= '0;
    end else if (lookup_valid) begin
      pred_valid_q <= 1'b1;
      pred_taken_q <= lk_hit;
      pred_pc_q    <= lookup_pc;
      pred_tgt_q   <= lk_hit ? btb_tgt_q[lk_bidx] : '0;
    end else begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_tgt_q   <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_q <= '0;
      mp_q <= '0;
    end else if (stat_clear) begin
      br_q <= '0;
      mp_q <= '0;
    end else if (upd_valid) begin
      br_q <= br_q + STAT_WIDTH'(1);
      if (upd_mispredict) mp_q <= mp_q + STAT_WIDTH'(1);
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign pred_pc          = pred_pc_q;
  assign pred_target      = pred_tgt_q;
  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: bimodal instance for most checks,
// a default gshare instance for history-indexing checks.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bp_enable = 1'b1;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;
  logic        stat_clear = 1'b0;

  logic        pred_valid, pred_taken;
  logic [31:0] pred_pc, pred_target, stat_br, stat_mp;
  logic        g_valid, g_taken;
  logic [31:0] g_pc, g_target, g_br, g_mp;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  branch_predictor #(.HIST_BITS(0)) dut (
    .clk(clk), .rst(rst), .bp_enable(bp_enable),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .stat_clear(stat_clear),
    .stat_branches(stat_br), .stat_mispredicts(stat_mp)
  );

  branch_predictor dut_g (
    .clk(clk), .rst(rst), .bp_enable(bp_enable),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(g_valid), .pred_pc(g_pc),
    .pred_taken(g_taken), .pred_target(g_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .stat_clear(stat_clear),
    .stat_branches(g_br), .stat_mispredicts(g_mp)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg, input logic mp);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk;
    upd_target = tg; upd_mispredict = mp;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_valid = 1'b1; lookup_pc = pc;
    tick();
    lookup_valid = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_valid", 32'(pred_valid), 32'd0);
    chk("rst_taken", 32'(pred_taken), 32'd0);
    chk("rst_pc", pred_pc, 32'd0);
    chk("rst_stat_br", stat_br, 32'd0);
    tick(); tick();
    rst = 1'b1;

    look(32'h4000_0010);
    chk("lk0_valid", 32'(pred_valid), 32'd1);
    chk("lk0_taken", 32'(pred_taken), 32'd0);
    chk("lk0_target", pred_target, 32'd0);
    chk("lk0_pc", pred_pc, 32'h4000_0010);
    chk("g_lk0_valid", 32'(g_valid), 32'd1);
    tick();
    chk("idle_valid", 32'(pred_valid), 32'd0);
    chk("idle_pc_hold", pred_pc, 32'h4000_0010);

    upd(32'h100, 1'b1, 32'h200, 1'b0);
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    look(32'h100);
    chk("bim_taken", 32'(pred_taken), 32'd1);
    chk("bim_target", pred_target, 32'h200);
    chk("g_hist3_taken", 32'(g_taken), 32'd0);
    chk("g_hist3_target", g_target, 32'd0);
    chk("stat_br_2", stat_br, 32'd2);

    upd(32'h100, 1'b1, 32'h200, 1'b1);
    for (int i = 0; i < 4; i++) upd(32'h100, 1'b1, 32'h200, 1'b0);
    look(32'h100);
    chk("g_hist3f_taken", 32'(g_taken), 32'd1);
    chk("g_hist3f_target", g_target, 32'h200);
    chk("sat_taken", 32'(pred_taken), 32'd1);

    upd(32'h100, 1'b0, 32'h0, 1'b1);
    look(32'h100);
    chk("sat_nt1_taken", 32'(pred_taken), 32'd1);
    chk("sat_nt1_target", pred_target, 32'h200);
    chk("g_hist3e_taken", 32'(g_taken), 32'd0);
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    look(32'h100);
    chk("sat_nt2_taken", 32'(pred_taken), 32'd0);
    chk("sat_nt2_target", pred_target, 32'd0);

    upd(32'h100, 1'b1, 32'h200, 1'b0);
    bp_enable = 1'b0;
    look(32'h100);
    chk("dis_taken", 32'(pred_taken), 32'd0);
    chk("dis_target", pred_target, 32'd0);
    bp_enable = 1'b1;
    look(32'h100);
    chk("en_taken", 32'(pred_taken), 32'd1);
    chk("stat_br_10", stat_br, 32'd10);
    chk("stat_mp_3", stat_mp, 32'd3);

    look(32'h100 + 32'd256);
    chk("alias_taken", 32'(pred_taken), 32'd0);
    chk("alias_target", pred_target, 32'd0);
    chk("alias_pc", pred_pc, 32'h200);

    lookup_valid = 1'b1; lookup_pc = 32'h104;
    upd(32'h104, 1'b1, 32'h300, 1'b0);
    chk("coll1_taken", 32'(pred_taken), 32'd0);
    upd(32'h104, 1'b1, 32'h300, 1'b0);
    lookup_valid = 1'b0;
    chk("coll2_taken", 32'(pred_taken), 32'd1);
    chk("coll2_target", pred_target, 32'h300);
    chk("stat_br_12", stat_br, 32'd12);

    stat_clear = 1'b1;
    upd(32'h108, 1'b1, 32'h400, 1'b1);
    stat_clear = 1'b0;
    chk("clr_br", stat_br, 32'd0);
    chk("clr_mp", stat_mp, 32'd0);
    upd(32'h108, 1'b1, 32'h400, 1'b1);
    chk("post_clr_br", stat_br, 32'd1);
    chk("post_clr_mp", stat_mp, 32'd1);

    lookup_valid = 1'b1; lookup_pc = 32'h104;
    tick();
    chk("pend_valid", 32'(pred_valid), 32'd1);
    chk("pend_taken", 32'(pred_taken), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(pred_valid), 32'd0);
    chk("arst_taken", 32'(pred_taken), 32'd0);
    chk("arst_pc", pred_pc, 32'd0);
    chk("arst_target", pred_target, 32'd0);
    chk("arst_stat_br", stat_br, 32'd0);
    chk("arst_stat_mp", stat_mp, 32'd0);
    lookup_valid = 1'b0;
    tick();
    rst = 1'b1;
    look(32'h104);
    chk("post_rst_taken", 32'(pred_taken), 32'd0);
    chk("post_rst_g_taken", 32'(g_taken), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
